// File: rtl/csa_resolve_seq_if.sv
// Operand/result handshake bundle for csa_resolve_seq.
// The master drives operands and out_ready; the slave (the resolver) drives the result side.
interface csa_resolve_seq_if #(
  parameter int Width = 24,
  parameter int Chunk = 8
);
  localparam int RW = Width + 2;

  logic             in_valid;
  logic             in_ready;
  logic [Width-1:0] in_sum;
  logic [Width-1:0] in_carry;
  logic             in_cout;
  logic             out_valid;
  logic             out_ready;
  logic [RW-1:0]    out_result;
  logic             out_ovf;

  modport master (
    output in_valid, in_sum, in_carry, in_cout, out_ready,
    input  in_ready, out_valid, out_result, out_ovf
  );

  modport slave (
    input  in_valid, in_sum, in_carry, in_cout, out_ready,
    output in_ready, out_valid, out_result, out_ovf
  );
endinterface

// File: rtl/csa_resolve_seq.sv
// Resolves a redundant sum/carry word to binary with a chunked, multi-cycle
// carry-propagate adder: Chunk bits per clock, NCHUNK compute cycles per operation.
module csa_resolve_seq #(
  parameter int Width = 24,
  parameter int Chunk = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  csa_resolve_seq_if.slave   bus,
  output logic               busy
);
  localparam int RW     = Width + 2;
  localparam int NCHUNK = (RW + Chunk - 1) / Chunk;
  localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state_reg, state_next;
  logic [RW-1:0]   x_reg, y_reg;
  logic [RW-1:0]   result_reg, result_next;
  logic            carry_reg, ovf_reg, valid_reg;
  logic [IW-1:0]   idx_reg;
  logic [NCHUNK-1:0] chunk_co;
  logic            last_chunk, computing;

  assign computing  = (state_reg == BUSY);
  assign last_chunk = (idx_reg == IW'(NCHUNK - 1));

  // One adder slice per chunk; only the slice selected by idx_reg updates the result.
  // The top slice is narrower when Chunk does not divide RW, so its carry-out is the true bit RW.
  generate
    for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_chunk
      localparam int LO = gi * Chunk;
      localparam int HI = ((gi + 1) * Chunk > RW) ? RW - 1 : (gi + 1) * Chunk - 1;
      localparam int W  = HI - LO + 1;

      logic [W:0] csum;
      assign csum = {1'b0, x_reg[HI:LO]} + {1'b0, y_reg[HI:LO]} + {{W{1'b0}}, carry_reg};
      assign chunk_co[gi] = csum[W];
      assign result_next[HI:LO] = (computing && idx_reg == IW'(gi)) ? csum[W-1:0]
                                                                  : result_reg[HI:LO];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (clear) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE:    if (bus.in_valid) state_next = BUSY;
        BUSY:    if (last_chunk) state_next = DONE;
        DONE:    if (bus.out_ready) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    bus.in_ready = (state_reg == IDLE);
    busy         = (state_reg != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_reg      <= '0;
      y_reg      <= '0;
      result_reg <= '0;
      carry_reg  <= 1'b0;
      ovf_reg    <= 1'b0;
      valid_reg  <= 1'b0;
      idx_reg    <= '0;
    end else if (clear) begin
      carry_reg <= 1'b0;
      idx_reg   <= '0;
      valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.in_valid) begin
            x_reg     <= {2'b00, bus.in_sum};
            y_reg     <= {bus.in_cout, bus.in_carry, 1'b0};
            carry_reg <= 1'b0;
            idx_reg   <= '0;
          end
        end
        BUSY: begin
          result_reg <= result_next;
          carry_reg  <= chunk_co[idx_reg];
          idx_reg    <= idx_reg + IW'(1);
          if (last_chunk) begin
            ovf_reg   <= chunk_co[idx_reg];
            valid_reg <= 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) valid_reg <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.out_valid  = valid_reg;
  assign bus.out_result = result_reg;
  assign bus.out_ovf    = ovf_reg;
endmodule

// File: tb/tb_csa_resolve_seq.sv
// Self-checking bench: directed table and corner sequences on a Chunk=8 instance,
// randomized operands against an arithmetic reference on a Chunk=5 instance.
module tb_csa_resolve_seq;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, clear8, clear5, busy8, busy5;
  int checks = 0;
  int failures = 0;

  csa_resolve_seq_if #(.Width(24), .Chunk(8)) if8 ();
  csa_resolve_seq_if #(.Width(24), .Chunk(5)) if5 ();

  csa_resolve_seq #(.Width(24), .Chunk(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .clear(clear8), .bus(if8.slave), .busy(busy8)
  );
  csa_resolve_seq #(.Width(24), .Chunk(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .clear(clear5), .bus(if5.slave), .busy(busy5)
  );

  typedef struct {
    logic [23:0] s;
    logic [23:0] c;
    logic        co;
    logic [25:0] r;
    logic        ovf;
  } vec_t;

  vec_t tbl [9];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Full transaction on the Chunk=8 instance; hold>0 adds a backpressure phase in DONE.
  task automatic run8(input logic [23:0] s, input logic [23:0] c, input logic co,
                      input logic [25:0] er, input logic eo, input string nm, input int hold);
    int lat;
    bit stable;
    if8.in_sum = s; if8.in_carry = c; if8.in_cout = co; if8.in_valid = 1'b1;
    check({nm, "_in_ready"}, 32'(if8.in_ready), 32'd1);
    @(posedge clk); #1;
    if8.in_valid = 1'b0;
    lat = 1;
    while (!if8.out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check({nm, "_latency"}, 32'(lat), 32'd5);
    check({nm, "_result"}, 32'(if8.out_result), 32'(er));
    check({nm, "_ovf"}, 32'(if8.out_ovf), 32'(eo));
    check({nm, "_done_in_ready"}, 32'(if8.in_ready), 32'd0);
    if (hold > 0) begin
      stable = 1'b1;
      for (int i = 0; i < hold; i++) begin
        if8.in_valid = 1'b1;
        if8.in_sum = 24'($urandom);
        if8.in_carry = 24'($urandom);
        if8.out_ready = 1'b0;
        @(posedge clk); #1;
        if (if8.out_result !== er || if8.out_ovf !== eo || !if8.out_valid ||
            if8.in_ready || !busy8) stable = 1'b0;
      end
      if8.in_valid = 1'b0;
      check({nm, "_backpressure_stable"}, 32'(stable), 32'd1);
    end
    if8.out_ready = 1'b1;
    @(posedge clk); #1;
    if8.out_ready = 1'b0;
    check({nm, "_post_valid"}, 32'(if8.out_valid), 32'd0);
    check({nm, "_post_busy"}, 32'(busy8), 32'd0);
    $display("txn c8 %s sum=%h carry=%h cout=%0d result=%h ovf=%0d lat=%0d",
             nm, s, c, co, er, eo, lat);
  endtask

  // Randomized transaction on the Chunk=5 instance against an arithmetic reference.
  task automatic run5(input int n);
    logic [23:0] s, c;
    logic co;
    longint unsigned tot;
    logic [25:0] er;
    logic eo;
    int lat, tries;
    bit done;
    s = 24'($urandom); c = 24'($urandom); co = 1'($urandom);
    case ($urandom_range(0, 7))
      0: begin s = '1; c = '1; co = 1'b1; end
      1: begin s = '0; c = '0; co = 1'b0; end
      default: ;
    endcase
    tot = longint'(s) + 2 * longint'(c) + (co ? (64'd1 << 25) : 64'd0);
    er = 26'(tot % (64'd1 << 26));
    eo = 1'(tot >> 26);
    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    if5.in_sum = s; if5.in_carry = c; if5.in_cout = co; if5.in_valid = 1'b1;
    check("rnd_in_ready", 32'(if5.in_ready), 32'd1);
    @(posedge clk); #1;
    if5.in_valid = 1'b0;
    lat = 1;
    while (!if5.out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("rnd_latency", 32'(lat), 32'd7);
    check("rnd_result", 32'(if5.out_result), 32'(er));
    check("rnd_ovf", 32'(if5.out_ovf), 32'(eo));
    done = 1'b0;
    tries = 0;
    while (!done) begin
      if5.out_ready = (tries >= 6) ? 1'b1 : 1'($urandom);
      done = if5.out_ready;
      @(posedge clk); #1;
      tries++;
    end
    if5.out_ready = 1'b0;
    check("rnd_post_busy", 32'(busy5), 32'd0);
    $display("txn c5 #%0d sum=%h carry=%h cout=%0d result=%h ovf=%0d lat=%0d",
             n, s, c, co, er, eo, lat);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{24'h000001, 24'h7FFFFF, 1'b0, 26'h0FFFFFF, 1'b0};
    tbl[1] = '{24'hFFFFFF, 24'hFFFFFF, 1'b1, 26'h0FFFFFD, 1'b1};
    tbl[2] = '{24'h000000, 24'h000000, 1'b0, 26'h0000000, 1'b0};
    tbl[3] = '{24'h000010, 24'h000008, 1'b0, 26'h0000020, 1'b0};
    tbl[4] = '{24'h123456, 24'h000000, 1'b1, 26'h2123456, 1'b0};
    tbl[5] = '{24'h800000, 24'h400000, 1'b0, 26'h1000000, 1'b0};
    tbl[6] = '{24'hFFFFFF, 24'h000000, 1'b1, 26'h2FFFFFF, 1'b0};
    tbl[7] = '{24'h000001, 24'hFFFFFF, 1'b1, 26'h3FFFFFF, 1'b0};
    tbl[8] = '{24'h000002, 24'hFFFFFF, 1'b1, 26'h0000000, 1'b1};

    rst_n = 1'b0; clear8 = 1'b0; clear5 = 1'b0;
    if8.in_valid = 1'b0; if8.in_sum = '0; if8.in_carry = '0; if8.in_cout = 1'b0; if8.out_ready = 1'b0;
    if5.in_valid = 1'b0; if5.in_sum = '0; if5.in_carry = '0; if5.in_cout = 1'b0; if5.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready", 32'(if8.in_ready), 32'd1);
    check("reset_out_valid", 32'(if8.out_valid), 32'd0);
    check("reset_result", 32'(if8.out_result), 32'd0);
    check("reset_ovf", 32'(if8.out_ovf), 32'd0);
    check("reset_busy", 32'(busy8), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++)
      run8(tbl[i].s, tbl[i].c, tbl[i].co, tbl[i].r, tbl[i].ovf, $sformatf("vec%0d", i), 0);

    // Backpressure: held in DONE for 10 cycles with new operands offered.
    run8(24'h000001, 24'h7FFFFF, 1'b0, 26'h0FFFFFF, 1'b0, "backpressure", 10);

    // clear in the same cycle as in_valid must not accept.
    if8.in_valid = 1'b1; clear8 = 1'b1;
    @(posedge clk); #1;
    if8.in_valid = 1'b0; clear8 = 1'b0;
    check("clear_vs_valid_busy", 32'(busy8), 32'd0);

    // Abort during the second BUSY cycle, then a fresh operation.
    if8.in_sum = 24'hFFFFFF; if8.in_carry = 24'hFFFFFF; if8.in_cout = 1'b1; if8.in_valid = 1'b1;
    @(posedge clk); #1;
    if8.in_valid = 1'b0;
    @(posedge clk); #1;
    clear8 = 1'b1;
    @(posedge clk); #1;
    clear8 = 1'b0;
    check("abort_busy", 32'(busy8), 32'd0);
    check("abort_out_valid", 32'(if8.out_valid), 32'd0);
    check("abort_in_ready", 32'(if8.in_ready), 32'd1);
    run8(24'h000010, 24'h000008, 1'b0, 26'h0000020, 1'b0, "after_abort", 0);

    // Asynchronous reset between edges in the middle of BUSY.
    if8.in_sum = 24'hABCDEF; if8.in_carry = 24'h123456; if8.in_cout = 1'b1; if8.in_valid = 1'b1;
    @(posedge clk); #1;
    if8.in_valid = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_busy", 32'(busy8), 32'd0);
    check("async_rst_in_ready", 32'(if8.in_ready), 32'd1);
    check("async_rst_out_valid", 32'(if8.out_valid), 32'd0);
    check("async_rst_result", 32'(if8.out_result), 32'd0);
    check("async_rst_ovf", 32'(if8.out_ovf), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_in_ready", 32'(if8.in_ready), 32'd1);
    check("post_rst_out_valid", 32'(if8.out_valid), 32'd0);
    run8(24'h000001, 24'h7FFFFF, 1'b0, 26'h0FFFFFF, 1'b0, "after_reset", 0);

    for (int n = 0; n < 1000; n++) run5(n);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/csa_resolve_seq.md
Name: csa_resolve_seq

Overview:
Consumes one redundant (sum/carry) word as produced by the team's 4:2 compressor trees. Resolves it to a binary result with a multi-cycle, chunked carry-propagate adder that handles Chunk bits per clock. It sits after the PE accumulation compressors, where a full-width single-cycle adder would break timing. Valid/ready handshakes are used on both sides.

Parameters:
Width, 24, bit width of the in_sum and in_carry vectors
Chunk, 8, bits resolved per cycle; legal range 1..Width+2
(derived) RW = Width+2, width of the result
(derived) NCHUNK = ceil(RW/Chunk), adder cycles per operation

Ports:
clk  input  1  clock, rising-edge
rst_n  input  1  asynchronous active-low reset
clear  input  1  synchronous abort, active-high
in_valid  input  1  operand word valid
in_ready  output  1  block can accept an operand word
in_sum  input  Width  redundant sum vector, weight 2^i
in_carry  input  Width  redundant carry vector, weight 2^(i+1)
in_cout  input  1  top carry-out, weight 2^(Width+1)
out_valid  output  1  result valid
out_ready  input  1  downstream accepts the result
out_result  output  RW  resolved value
out_ovf  output  1  carry out of bit RW-1
busy  output  1  high in BUSY or DONE

Behaviour:
- Clock and reset: one clock domain. Reset is asynchronous and active-low (rst_n); all state clears immediately on rst_n low.
- Arithmetic:
  - Operand X = zero-extended in_sum (RW bits).
  - Operand Y = {in_cout, in_carry, 1'b0} (RW bits).
  - out_result = (X+Y) mod 2^RW.
  - out_ovf = bit RW of X+Y.
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_result=0, out_ovf=0, busy=0, internal carry=0, chunk index=0.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - On the edge where in_valid&in_ready: register X and Y, clear the carry register, set index=0, go to BUSY.
- BUSY:
  - in_ready=0.
  - Each cycle, add the bits of chunk k of X and Y plus the carry register, write them into the result register, store the carry, then index++.
  - The last chunk covers only bits (NCHUNK-1)*Chunk..RW-1 when Chunk does not divide RW. Its carry-out goes to out_ovf.
  - After processing chunk NCHUNK-1, go to DONE.
- DONE:
  - out_valid=1; out_result and out_ovf are held stable.
  - On out_valid&out_ready: go to IDLE. out_valid drops on the next edge.
- Latency: out_valid rises exactly NCHUNK+1 rising edges after the accepting edge. That is 1 capture edge plus NCHUNK compute edges; BUSY lasts NCHUNK cycles.
- Throughput: one operation per NCHUNK+2 cycles minimum with out_ready tied high. No overlap: in_ready=0 in BUSY and DONE. in_valid in those states is ignored and does not stall.
- out_result:
  - Retains its last value after handshake until the next operation's first compute edge.
  - Only the DONE-state value is architecturally defined.
- clear:
  - In any state, clear=1 at an edge forces IDLE and out_valid=0, and zeroes the carry and index.
  - An in_valid in the same cycle as clear is NOT accepted.
  - clear has priority over all handshakes.
- rst_n low mid-operation: immediate return to reset values. The in-flight operation is lost with no partial output.
- Back-to-back: in DONE with out_ready=1, the next operand may be accepted no earlier than the edge after the return to IDLE (in_ready is combinationally state==IDLE).
- busy = (state != IDLE).
- Outputs are registered except in_ready and busy, which are decoded from the state register.

Test Plan:
- Basic resolve (Width=24, Chunk=8, NCHUNK=4):
  - Stimulus: in_sum=0x000001, in_carry=0x7FFFFF, in_cout=0.
  - Response: out_result=0x0FFFFFF, out_ovf=0.
  - out_valid must rise 5 edges after the accept edge and stay high until out_ready.
- Maximum operands:
  - Stimulus: in_sum=0xFFFFFF, in_carry=0xFFFFFF, in_cout=1.
  - Response: out_result=0x0FFFFFD, out_ovf=1. This checks the inter-chunk carry ripple through all 4 chunks.
- Backpressure:
  - Stimulus: hold out_ready=0 for 10 cycles in DONE while in_valid=1 with new operands.
  - Response: out_result stable, in_ready=0, busy=1, no operand accepted. After out_ready=1, exactly one handshake, then IDLE.
- Abort:
  - Stimulus: assert clear in the 2nd BUSY cycle, then in the following cycle apply in_sum=0x000010, in_carry=0x000008, in_cout=0.
  - Response: out_valid never asserts for the aborted operation. The new operation yields out_result=0x0000020.
- Async reset:
  - Stimulus: drop rst_n mid-BUSY, between clock edges.
  - Response: outputs go to reset values without waiting for a clock edge. After release, in_ready=1 and out_valid=0.
- Non-dividing chunk (Chunk=5, NCHUNK=6):
  - Stimulus: random 1000 operands with random out_ready.
  - Response: results match the golden (X+Y) mod 2^26 and the carry bit. out_valid rises 7 edges after each accept.
